// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: reads a multiplexed 7-segment bus back into a frame of decoded digits
// Ports: clk, rst (sync, active-high); seg {a..g}, 1 = lit; n_en active-low digit selects;
//   value (4 bits per position), blank, err per position; frame_valid one-cycle pulse;
//   frame_err qualified by frame_valid.
// Build option SEG7_DP_EN: seg widens to 8 bits with seg[7] = decimal point, adds dp[DIGITS].
module seg7_scan_reader #(
  parameter int DIGITS = 4,
  parameter int STABLE = 3
) (
  input  logic                clk,
  input  logic                rst,
`ifdef SEG7_DP_EN
  input  logic [7:0]          seg,
  output logic [DIGITS-1:0]   dp,
`else
  input  logic [6:0]          seg,
`endif
  input  logic [DIGITS-1:0]   n_en,
  output logic [4*DIGITS-1:0] value,
  output logic [DIGITS-1:0]   blank,
  output logic [DIGITS-1:0]   err,
  output logic                frame_valid,
  output logic                frame_err
);
`ifdef SEG7_DP_EN
  localparam int SW = 8;
`else
  localparam int SW = 7;
`endif
  localparam int IW = DIGITS + SW;
  localparam logic [3:0] CMAX = 4'(STABLE - 1);
  // returns {err, blank, value}
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'h7E:   decode = 6'h00;
      7'h30:   decode = 6'h01;
      7'h6D:   decode = 6'h02;
      7'h79:   decode = 6'h03;
      7'h33:   decode = 6'h04;
      7'h5B:   decode = 6'h05;
      7'h5F:   decode = 6'h06;
      7'h70:   decode = 6'h07;
      7'h7F:   decode = 6'h08;
      7'h7B:   decode = 6'h09;
      7'h00:   decode = 6'h1F;
      default: decode = 6'h2E;
    endcase
  endfunction
  logic [IW-1:0]       s0_q, s0_d, s1_q, s1_d, pat_q, pat_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic [DIGITS-1:0]   cap_q, cap_d;
  logic                multi_q, multi_d;
  logic [4*DIGITS-1:0] sh_val_q, sh_val_d, value_q, value_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d, blank_q, blank_d;
  logic [DIGITS-1:0]   sh_err_q, sh_err_d, err_q, err_d;
  logic                frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
  logic                eq, one;
  logic [DIGITS-1:0]   sel;
  logic [5:0]          dec;
`ifdef SEG7_DP_EN
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, dp_q, dp_d;
`endif
  always_comb begin
    s0_d = {n_en, seg};
    s1_d = s0_q;
    eq = s0_q == s1_q;
    cnt_d = !eq ? 4'd0 : cnt_q == CMAX ? cnt_q : cnt_q + 4'd1;
    // acceptance is pipelined one edge so the write lands STABLE+1 edges after the pattern appears
    acc_d = eq && cnt_q == CMAX - 4'd1;
    pat_d = s0_q;
    sel = ~pat_q[IW-1:SW];
    dec = decode(pat_q[6:0]);
    one = |sel && ~|(sel & (sel - DIGITS'(1)));
    sh_val_d = sh_val_q;
    sh_blank_d = sh_blank_q;
    sh_err_d = sh_err_q;
`ifdef SEG7_DP_EN
    sh_dp_d = sh_dp_q;
    dp_d = dp_q;
`endif
    for (int i = 0; i < DIGITS; i++)
      if (acc_q && one && sel[i]) begin
        sh_val_d[4*i +: 4] = dec[3:0];
        sh_blank_d[i] = dec[4];
        sh_err_d[i] = dec[5];
`ifdef SEG7_DP_EN
        sh_dp_d[i] = pat_q[7];
`endif
      end
    cap_d = cap_q | (acc_q && one ? sel : '0);
    multi_d = multi_q | (acc_q && |sel && !one);
    value_d = value_q;
    blank_d = blank_q;
    err_d = err_q;
    frame_valid_d = 1'b0;
    frame_err_d = 1'b0;
    // captured only reaches all-ones through a write, so this fires once per completed frame
    if (&cap_d) begin
      value_d = sh_val_d;
      blank_d = sh_blank_d;
      err_d = sh_err_d;
`ifdef SEG7_DP_EN
      dp_d = sh_dp_d;
`endif
      frame_valid_d = 1'b1;
      frame_err_d = |sh_err_d | multi_d;
      cap_d = '0;
      multi_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
      pat_q <= '0;
      cnt_q <= '0;
      acc_q <= 1'b0;
      cap_q <= '0;
      multi_q <= 1'b0;
      sh_val_q <= '0;
      sh_blank_q <= '0;
      sh_err_q <= '0;
      value_q <= '0;
      blank_q <= '1;
      err_q <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SEG7_DP_EN
      sh_dp_q <= '0;
      dp_q <= '0;
`endif
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      pat_q <= pat_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      cap_q <= cap_d;
      multi_q <= multi_d;
      sh_val_q <= sh_val_d;
      sh_blank_q <= sh_blank_d;
      sh_err_q <= sh_err_d;
      value_q <= value_d;
      blank_q <= blank_d;
      err_q <= err_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q <= frame_err_d;
`ifdef SEG7_DP_EN
      sh_dp_q <= sh_dp_d;
      dp_q <= dp_d;
`endif
    end
  end
  assign value = value_q;
  assign blank = blank_q;
  assign err = err_q;
  assign frame_valid = frame_valid_q;
  assign frame_err = frame_err_q;
`ifdef SEG7_DP_EN
  assign dp = dp_q;
`endif
endmodule
